// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 fetch-address path.
package msrv32_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_EPC  = 2'd1,
        PC_TRAP = 2'd2,
        PC_NEXT = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        WAIT      = 2'd2,
        WAIT_PEND = 2'd3
    } pc_state_e;

endpackage

// File: rtl/msrv32_redirect_buf.sv
// Holds one redirect target that arrived while the instruction bus was stalled.
module msrv32_redirect_buf
    import msrv32_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_capture,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_addr,
    output logic            o_pending,
    output logic [XLEN-1:0] o_addr
);

    logic            r_pending;
    logic [XLEN-1:0] r_addr;

    // Capture takes priority so a newer redirect always overwrites the older one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
        end else if (i_capture) begin
            r_pending <= 1'b1;
            r_addr    <= i_addr;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;

endmodule

// File: rtl/msrv32_pc_gen.sv
// Fetch-address register with next-PC selection, wait-state hold and redirect buffering.
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter int unsigned      XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  BOOT_ADDRESS = '0,
    parameter int unsigned      IALIGN       = 32,
    parameter int unsigned      STALL_CNT_W  = 16
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_in,
    input  logic [1:0]             pc_src_in,
    input  logic                   branch_taken_in,
    input  logic [XLEN-1:0]        iaddr_in,
    input  logic [XLEN-1:0]        epc_in,
    input  logic [XLEN-1:0]        trap_address_in,
    input  logic                   ahb_ready_in,
    output logic [XLEN-1:0]        iaddr_out,
    output logic                   iaddr_valid_out,
    output logic [XLEN-1:0]        pc_plus_4_out,
    output logic                   misaligned_instr_logic_out,
    output logic                   redirect_pending_out,
    output logic [STALL_CNT_W-1:0] stall_cycles_out
);

    localparam logic [XLEN-1:0]        PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]        LSB_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    pc_state_e              r_state, w_state_d;
    logic [XLEN-1:0]        r_iaddr, w_iaddr_d;
    logic                   r_valid, w_valid_d;
    logic [STALL_CNT_W-1:0] r_stall;

    logic            w_mis, w_rd, w_capture, w_clear, w_pending;
    logic [XLEN-1:0] w_target, w_seq, w_run_next, w_pend_addr;

    assign w_mis = (IALIGN == 32) && (pc_src_in == PC_NEXT) && branch_taken_in && iaddr_in[1];
    assign w_rd  = (pc_src_in != PC_NEXT) || (branch_taken_in && !w_mis);
    assign w_seq = r_iaddr + PC_STEP;

    always_comb begin
        w_target = BOOT_ADDRESS;
        unique case (pc_src_e'(pc_src_in))
            PC_BOOT: w_target = BOOT_ADDRESS;
            PC_EPC:  w_target = epc_in;
            PC_TRAP: w_target = trap_address_in;
            PC_NEXT: w_target = iaddr_in & LSB_MASK;
        endcase
    end

    // A misaligned taken branch leaves the PC where it is so the trap unit can redirect.
    assign w_run_next = w_rd ? w_target : (w_mis ? r_iaddr : w_seq);

    always_comb begin
        w_state_d = r_state;
        w_iaddr_d = r_iaddr;
        w_valid_d = r_valid;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_valid_d = 1'b1;
                w_state_d = RUN;
            end
            RUN, WAIT: begin
                if (ahb_ready_in) begin
                    w_iaddr_d = w_run_next;
                    w_state_d = RUN;
                end else if (w_rd) begin
                    w_capture = 1'b1;
                    w_state_d = WAIT_PEND;
                end else begin
                    w_state_d = WAIT;
                end
            end
            WAIT_PEND: begin
                if (ahb_ready_in) begin
                    w_iaddr_d = w_rd ? w_target : w_pend_addr;
                    w_clear   = 1'b1;
                    w_state_d = RUN;
                end else if (w_rd) begin
                    w_capture = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_state <= BOOT;
            r_iaddr <= BOOT_ADDRESS;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_iaddr <= w_iaddr_d;
            r_valid <= w_valid_d;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_stall <= '0;
        end else if ((r_state == WAIT || r_state == WAIT_PEND) && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_ONE;
        end
    end

    msrv32_redirect_buf #(
        .XLEN(XLEN)
    ) u_redirect_buf (
        .i_clk     (ms_riscv32_mp_clk_in),
        .i_rst_n   (ms_riscv32_mp_rst_in),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_addr    (w_target),
        .o_pending (w_pending),
        .o_addr    (w_pend_addr)
    );

    assign iaddr_out                  = r_iaddr;
    assign iaddr_valid_out            = r_valid;
    assign pc_plus_4_out              = w_seq;
    assign misaligned_instr_logic_out = w_mis;
    assign redirect_pending_out       = w_pending;
    assign stall_cycles_out           = r_stall;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Directed scoreboard bench for msrv32_pc_gen, with IALIGN=32 and IALIGN=16 instances.
module tb_msrv32_pc_gen;

    localparam int unsigned SW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic        br_taken;
    logic [31:0] iaddr_in, epc, trap_addr;
    logic        ready;

    logic [31:0]   iaddr_a, pc4_a, iaddr_b, pc4_b;
    logic          valid_a, mis_a, pend_a, valid_b, mis_b, pend_b;
    logic [SW-1:0] stall_a, stall_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    msrv32_pc_gen #(
        .XLEN(32), .BOOT_ADDRESS(32'h0), .IALIGN(32), .STALL_CNT_W(SW)
    ) u_dut_a (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_in       (rst_n),
        .pc_src_in                  (pc_src),
        .branch_taken_in            (br_taken),
        .iaddr_in                   (iaddr_in),
        .epc_in                     (epc),
        .trap_address_in            (trap_addr),
        .ahb_ready_in               (ready),
        .iaddr_out                  (iaddr_a),
        .iaddr_valid_out            (valid_a),
        .pc_plus_4_out              (pc4_a),
        .misaligned_instr_logic_out (mis_a),
        .redirect_pending_out       (pend_a),
        .stall_cycles_out           (stall_a)
    );

    msrv32_pc_gen #(
        .XLEN(32), .BOOT_ADDRESS(32'h0), .IALIGN(16), .STALL_CNT_W(SW)
    ) u_dut_b (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_in       (rst_n),
        .pc_src_in                  (pc_src),
        .branch_taken_in            (br_taken),
        .iaddr_in                   (iaddr_in),
        .epc_in                     (epc),
        .trap_address_in            (trap_addr),
        .ahb_ready_in               (ready),
        .iaddr_out                  (iaddr_b),
        .iaddr_valid_out            (valid_b),
        .pc_plus_4_out              (pc4_b),
        .misaligned_instr_logic_out (mis_b),
        .redirect_pending_out       (pend_b),
        .stall_cycles_out           (stall_b)
    );

    // sel: 0 iaddr, 1 valid, 2 mis, 3 pending, 4 stall, 5 pc+4 (instance a); 10.. instance b
    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return iaddr_a;
            1:       return {31'b0, valid_a};
            2:       return {31'b0, mis_a};
            3:       return {31'b0, pend_a};
            4:       return {28'b0, stall_a};
            5:       return pc4_a;
            10:      return iaddr_b;
            12:      return {31'b0, mis_b};
            13:      return {31'b0, pend_b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic drive(input logic [1:0] src, input logic bt, input logic [31:0] tgt,
                         input logic rdy);
        pc_src   = src;
        br_taken = bt;
        iaddr_in = tgt;
        ready    = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        epc       = 32'h0;
        trap_addr = 32'h0;

        // Reset held for three cycles
        repeat (3) tick();
        expect_val("rst_iaddr", 0, 32'h0);
        expect_val("rst_valid", 1, 32'h0);
        expect_val("rst_pend", 3, 32'h0);
        expect_val("rst_stall", 4, 32'h0);
        settle();

        rst_n = 1'b1;
        expect_val("boot_iaddr", 0, 32'h0);
        expect_val("boot_valid", 1, 32'h1);
        tick();
        expect_val("seq_4", 0, 32'h4);
        tick();
        expect_val("seq_8", 0, 32'h8);
        expect_val("pc4_c", 5, 32'hC);
        tick();

        drive(2'd3, 1'b1, 32'h100, 1'b1);
        expect_val("br_100", 0, 32'h100);
        tick();

        // Odd target: bit 0 cleared, not misaligned
        drive(2'd3, 1'b1, 32'h201, 1'b1);
        expect_val("mis_201", 2, 32'h0);
        settle();
        expect_val("br_200", 0, 32'h200);
        tick();

        // Bit-1 target: misaligned on IALIGN=32, taken on IALIGN=16
        drive(2'd3, 1'b1, 32'h302, 1'b1);
        expect_val("mis_302_a", 2, 32'h1);
        expect_val("mis_302_b", 12, 32'h0);
        settle();
        expect_val("hold_200_a", 0, 32'h200);
        expect_val("br_302_b", 10, 32'h302);
        tick();

        trap_addr = 32'h40;
        drive(2'd2, 1'b0, 32'h0, 1'b1);
        expect_val("trap_40", 0, 32'h40);
        expect_val("trap_40_b", 10, 32'h40);
        tick();

        // Three stall cycles, trap arrives in the first
        trap_addr = 32'h80;
        drive(2'd2, 1'b0, 32'h0, 1'b0);
        expect_val("st1_hold", 0, 32'h40);
        expect_val("st1_pend", 3, 32'h1);
        expect_val("st1_stall", 4, 32'h0);
        tick();
        drive(2'd3, 1'b0, 32'h0, 1'b0);
        expect_val("st2_hold", 0, 32'h40);
        expect_val("st2_stall", 4, 32'h1);
        tick();
        expect_val("st3_stall", 4, 32'h2);
        tick();
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        expect_val("rel_80", 0, 32'h80);
        expect_val("rel_pend", 3, 32'h0);
        expect_val("rel_stall", 4, 32'h3);
        tick();

        // Pending overwrite: trap 0x60 then EPC 0x1C, latest wins
        trap_addr = 32'h60;
        drive(2'd2, 1'b0, 32'h0, 1'b0);
        expect_val("ow_pend", 3, 32'h1);
        tick();
        epc = 32'h1C;
        drive(2'd1, 1'b0, 32'h0, 1'b0);
        expect_val("ow_hold", 0, 32'h80);
        expect_val("ow_stall", 4, 32'h4);
        tick();
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        expect_val("ow_1c", 0, 32'h1C);
        expect_val("ow_stall2", 4, 32'h5);
        expect_val("ow_clr", 3, 32'h0);
        tick();

        // Plain wait state without redirect
        drive(2'd3, 1'b0, 32'h0, 1'b0);
        expect_val("w_hold", 0, 32'h1C);
        expect_val("w_nopend", 3, 32'h0);
        tick();
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        expect_val("w_20", 0, 32'h20);
        expect_val("w_stall", 4, 32'h6);
        tick();

        // Misaligned branch in a wait state is not buffered on IALIGN=32
        drive(2'd3, 1'b1, 32'h102, 1'b0);
        expect_val("wm_nopend_a", 3, 32'h0);
        expect_val("wm_pend_b", 13, 32'h1);
        tick();
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        expect_val("wm_24_a", 0, 32'h24);
        expect_val("wm_102_b", 10, 32'h102);
        expect_val("wm_stall", 4, 32'h7);
        tick();

        // Concurrent trap at release beats the pending address
        trap_addr = 32'h50;
        drive(2'd2, 1'b0, 32'h0, 1'b0);
        tick();
        trap_addr = 32'h90;
        drive(2'd2, 1'b0, 32'h0, 1'b1);
        expect_val("cc_90", 0, 32'h90);
        expect_val("cc_stall", 4, 32'h8);
        tick();

        // Reset while a redirect is pending
        epc = 32'h44;
        drive(2'd1, 1'b0, 32'h0, 1'b0);
        expect_val("rp_pend", 3, 32'h1);
        tick();
        rst_n = 1'b0;
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        expect_val("rp_iaddr", 0, 32'h0);
        expect_val("rp_valid", 1, 32'h0);
        expect_val("rp_pend0", 3, 32'h0);
        expect_val("rp_stall0", 4, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_val("rp_seq4", 0, 32'h4);
        tick();

        // Sequential wrap at the top of the address space
        trap_addr = 32'hFFFF_FFFC;
        drive(2'd2, 1'b0, 32'h0, 1'b1);
        expect_val("wr_top", 0, 32'hFFFF_FFFC);
        expect_val("wr_pc4", 5, 32'h0);
        tick();
        drive(2'd3, 1'b0, 32'h0, 1'b1);
        expect_val("wr_zero", 0, 32'h0);
        tick();

        // Stall counter saturates at all-ones
        drive(2'd3, 1'b0, 32'h0, 1'b0);
        repeat (20) tick();
        expect_val("sat_stall", 4, 32'hF);
        expect_val("sat_hold", 0, 32'h0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msrv32_pc_gen.md
Name: msrv32_pc_gen

Overview:
Parametrised program-counter generator for the msrv32 fetch path. It owns the fetch-address register and selects the next address from boot, EPC, trap vector, branch target or sequential PC. Unlike the combinational PC mux, it holds the issued address across AHB wait states instead of driving 0. It also buffers a redirect that arrives during a wait state, and counts stall cycles. It sits between the trap/branch units and the instruction-side AHB master.

Parameters:
XLEN, 32, address/data width (≥ 32)
BOOT_ADDRESS, {XLEN{1'b0}}, reset/boot fetch address (must be 4-byte aligned)
IALIGN, 32, instruction alignment: 32 checks target bit 1; 16 disables misalignment detection
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
ms_riscv32_mp_clk_in  in  1  clock, rising edge
ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-low
pc_src_in  in  2  0 boot, 1 epc, 2 trap, 3 next
branch_taken_in  in  1  branch/jump resolved taken (meaningful only when pc_src_in=3)
iaddr_in  in  XLEN  branch/jump target
epc_in  in  XLEN  return address from CSR unit
trap_address_in  in  XLEN  trap vector from CSR unit
ahb_ready_in  in  1  instruction bus accepts address this cycle
iaddr_out  out  XLEN  registered fetch address
iaddr_valid_out  out  1  iaddr_out is a fetch request
pc_plus_4_out  out  XLEN  iaddr_out + 4, combinational
misaligned_instr_logic_out  out  1  taken branch to misaligned target, combinational
redirect_pending_out  out  1  a buffered redirect awaits ahb_ready_in
stall_cycles_out  out  STALL_CNT_W  saturating count of cycles in WAIT/WAIT_PEND

Behaviour:
- All state updates on the rising edge. Reset (rst_in=0 at an edge) sets:
  - iaddr_out = BOOT_ADDRESS
  - iaddr_valid_out = 0
  - pending flag = 0, pending address = 0
  - stall_cycles_out = 0
  - state = BOOT
- Reset asserted mid-operation discards any pending redirect and resets the stall counter.
- Redirect request (combinational):
  - rd = (pc_src_in != 3) | (branch_taken_in & ~mis).
  - Target: BOOT_ADDRESS / epc_in / trap_address_in for src 0 / 1 / 2.
  - For src 3, target is {iaddr_in[XLEN-1:1], 1'b0} (bit 0 always cleared).
- Misalignment:
  - mis = (IALIGN==32) & (pc_src_in==3) & branch_taken_in & iaddr_in[1].
  - misaligned_instr_logic_out = mis.
  - A misaligned branch is not taken: iaddr_out holds and is not advanced, so the trap unit can redirect on the next cycle.
- Sequential step is always +4, wrapping modulo 2^XLEN (0xFFFFFFFC+4 = 0).
- FSM:
  - BOOT: first edge with rst_in=1 sets iaddr_valid_out=1 and goes to RUN. iaddr_out stays BOOT_ADDRESS. Inputs are ignored.
  - RUN, ahb_ready_in=1: iaddr_out <= rd ? target : (mis ? iaddr_out : iaddr_out+4). Stay in RUN.
  - RUN, ahb_ready_in=0: iaddr_out holds. If rd, latch target, set pending, go to WAIT_PEND; else go to WAIT.
  - WAIT, ready=0: hold. rd latches target and moves to WAIT_PEND.
  - WAIT, ready=1: behaves as RUN with ready=1, then goes to RUN.
  - WAIT_PEND, ready=0: a new rd overwrites the pending address (latest wins). Hold.
  - WAIT_PEND, ready=1: iaddr_out <= rd ? target : pending address. Clear pending. Go to RUN.
- redirect_pending_out = 1 exactly in WAIT_PEND.
- stall_cycles_out increments in every cycle spent in WAIT or WAIT_PEND and saturates at all-ones.
- A misaligned branch during a wait state is not buffered.
- Latency: a redirect presented with ready=1 appears on iaddr_out in the next cycle.

Decomposition:
- Package msrv32_pkg: pc_src encodings (PC_BOOT=0, PC_EPC=1, PC_TRAP=2, PC_NEXT=3), FSM state enum (BOOT, RUN, WAIT, WAIT_PEND), default XLEN.
- One natural sub-module: msrv32_redirect_buf (pending flag + address register with capture/overwrite/clear). The FSM and counter stay in the top.

Test Plan:
- Reset low 3 cycles, then release with ready=1, src=3, no branch → iaddr_out 0x0 (valid 0) → 0x0 (valid 1) → 0x4 → 0x8.
- At iaddr_out=0x100, ready=1, branch_taken=1, iaddr_in=0x201 → next cycle iaddr_out=0x200, misaligned=0.
- branch_taken=1, iaddr_in=0x302 (IALIGN=32) → misaligned=1 same cycle, iaddr_out holds. Repeat with IALIGN=16 → iaddr_out=0x302, misaligned=0.
- ready=0 for 3 cycles from iaddr_out=0x40:
  - src=2, trap_address=0x80 in stall cycle 1 → iaddr_out holds 0x40, redirect_pending=1.
  - ready returns → iaddr_out=0x80, pending=0, stall_cycles_out=3.
- In WAIT_PEND (pending 0x80), src=1 with epc=0x1C while ready=0 → pending overwritten. Next ready=1 with src=3 → iaddr_out=0x1C.
- In WAIT_PEND with ready=1 and a concurrent trap to 0x90 → 0x90 wins. Separately, reset asserted in WAIT_PEND → pending cleared, iaddr_out=BOOT_ADDRESS, stall count 0.
